// File: rtl/bsd_pkg.sv
// Shared constants and width helper for the bit-splitter deserialiser.
package bsd_pkg;

  localparam int unsigned BSD_NUM_CH = 2;
  localparam int unsigned BSD_WORD_W = 4;

  // Bits needed to encode values 0..value-1, never less than one.
  function automatic int unsigned bsd_clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) r = 32'(i + 1);
    end
    return r;
  endfunction

  localparam int unsigned BSD_SEL_W = bsd_clog2(BSD_NUM_CH);

endpackage

// File: rtl/bsd_lane.sv
// One deserialiser lane: shift register, bit counter, holding register, valid and sticky overflow.
// Build option BSD_MSB_FIRST_EN shifts the first received bit into the word MSB.
module bsd_lane
  import bsd_pkg::*;
#(
  parameter int unsigned WORD_W = BSD_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en_i,
  input  logic              in_bit_i,
  input  logic              flush_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_word_o,
  output logic              overflow_o
);

  localparam int unsigned CNT_W = bsd_clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [WORD_W-1:0] shifted_c;
  logic              pop_c;
  logic              free_c;

`ifdef BSD_MSB_FIRST_EN
  assign shifted_c = {shreg_q[WORD_W-2:0], in_bit_i};
`else
  assign shifted_c = {in_bit_i, shreg_q[WORD_W-1:1]};
`endif

  assign pop_c  = valid_q & out_ready_i;
  // Holding register can accept a word this edge if empty or being drained.
  assign free_c = ~valid_q | out_ready_i;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    if (pop_c) valid_d = 1'b0;

    if (flush_i) begin
      shreg_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (cnt_q == CNT_FULL) begin
      // A finished word is parked in the shift register.
      if (free_c) begin
        hold_d  = shreg_q;
        valid_d = 1'b1;
        if (shift_en_i) begin
          shreg_d = shifted_c;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end else if (shift_en_i) begin
        ovf_d = 1'b1;
      end
    end else if (shift_en_i) begin
      shreg_d = shifted_c;
      if (cnt_q == CNT_LAST) begin
        if (free_c) begin
          hold_d  = shifted_c;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = CNT_FULL;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_word_o  = hold_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/bit_split_deser.sv
// N-lane serial-to-parallel deserialiser: decodes the lane select and flattens lane words.
// Build option BSD_MSB_FIRST_EN selects MSB-first assembly in every lane.
module bit_split_deser
  import bsd_pkg::*;
#(
  parameter  int unsigned NUM_CH = BSD_NUM_CH,
  parameter  int unsigned WORD_W = BSD_WORD_W,
  localparam int unsigned SEL_W  = bsd_clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_CH-1:0]        in_data,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*WORD_W-1:0] out_word,
  output logic [NUM_CH-1:0]        overflow
);

  logic [NUM_CH-1:0] shift_en_c;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    // Selects beyond NUM_CH-1 match no lane and are silently ignored.
    assign shift_en_c[k] = in_valid & (in_sel == SEL_W'(k));

    bsd_lane #(
      .WORD_W (WORD_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .shift_en_i  (shift_en_c[k]),
      .in_bit_i    (in_data[k]),
      .flush_i     (flush),
      .out_ready_i (out_ready[k]),
      .out_valid_o (out_valid[k]),
      .out_word_o  (out_word[k*WORD_W +: WORD_W]),
      .overflow_o  (overflow[k])
    );
  end

endmodule

// File: tb/tb_bit_split_deser.sv
// Scoreboard bench for bit_split_deser: directed scenarios then random beats against a queue-based model.
module tb_bit_split_deser;
  import bsd_pkg::*;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WORD_W = 4;
  localparam int unsigned SEL_W  = bsd_clog2(NUM_CH);

`ifdef BSD_MSB_FIRST_EN
  localparam logic [3:0] EXP_A   = 4'b1011;
  localparam logic [3:0] EXP_W1  = 4'b1100;
  localparam logic [3:0] EXP_IL1 = 4'b0010;
  localparam logic [3:0] EXP_W3  = 4'b0111;
  localparam logic [3:0] EXP_W4  = 4'b1010;
`else
  localparam logic [3:0] EXP_A   = 4'b1101;
  localparam logic [3:0] EXP_W1  = 4'b0011;
  localparam logic [3:0] EXP_IL1 = 4'b0100;
  localparam logic [3:0] EXP_W3  = 4'b1110;
  localparam logic [3:0] EXP_W4  = 4'b0101;
`endif
  localparam logic [3:0] EXP_R  = 4'b0110;
  localparam logic [3:0] EXP_W2 = 4'b1001;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_CH-1:0]        in_data;
  logic                     flush;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*WORD_W-1:0] out_word;
  logic [NUM_CH-1:0]        overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: per lane, collected bits, a parked word, the presented word and the sticky flag.
  bit              m_bits   [NUM_CH][$];
  bit              m_pend_v [NUM_CH];
  logic [WORD_W-1:0] m_pend_w [NUM_CH];
  bit              m_hold_v [NUM_CH];
  logic [WORD_W-1:0] m_hold_w [NUM_CH];
  bit              m_ovf    [NUM_CH];
  logic [WORD_W-1:0] exp_q    [NUM_CH][$];

  bit_split_deser #(
    .NUM_CH (NUM_CH),
    .WORD_W (WORD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] assemble(input int k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
`ifdef BSD_MSB_FIRST_EN
      w[int'(WORD_W) - 1 - i] = m_bits[k][i];
`else
      w[i] = m_bits[k][i];
`endif
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < int'(NUM_CH); k++) begin
      m_bits[k].delete();
      exp_q[k].delete();
      m_pend_v[k] = 1'b0;
      m_pend_w[k] = '0;
      m_hold_v[k] = 1'b0;
      m_hold_w[k] = '0;
      m_ovf[k]    = 1'b0;
    end
  endtask

  task automatic model_load(input int k, input logic [WORD_W-1:0] w);
    m_hold_v[k] = 1'b1;
    m_hold_w[k] = w;
    exp_q[k].push_back(w);
  endtask

  task automatic model_step(input bit v, input int sel, input logic [NUM_CH-1:0] data,
                            input bit fl, input logic [NUM_CH-1:0] rdy);
    for (int k = 0; k < int'(NUM_CH); k++) begin
      bit pop, free, sh;
      logic [WORD_W-1:0] w;
      pop  = m_hold_v[k] && rdy[k];
      free = !m_hold_v[k] || rdy[k];
      sh   = v && !fl && (sel == k);
      if (pop) m_hold_v[k] = 1'b0;
      if (fl) begin
        m_bits[k].delete();
        m_pend_v[k] = 1'b0;
        m_ovf[k]    = 1'b0;
      end else if (m_pend_v[k]) begin
        if (free) begin
          model_load(k, m_pend_w[k]);
          m_pend_v[k] = 1'b0;
          if (sh) m_bits[k].push_back(data[k]);
        end else if (sh) begin
          m_ovf[k] = 1'b1;
        end
      end else if (sh) begin
        m_bits[k].push_back(data[k]);
        if (m_bits[k].size() == int'(WORD_W)) begin
          w = assemble(k);
          m_bits[k].delete();
          if (free) model_load(k, w);
          else begin
            m_pend_v[k] = 1'b1;
            m_pend_w[k] = w;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, then advance the model past the consuming edge.
  task automatic cycle(input bit v, input int sel, input logic [NUM_CH-1:0] data,
                       input bit fl, input logic [NUM_CH-1:0] rdy);
    in_valid  = v;
    in_sel    = SEL_W'(sel);
    in_data   = data;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
    if (!reset) model_step(v, sel, data, fl, rdy);
  endtask

  task automatic beat(input int lane, input bit b, input logic [NUM_CH-1:0] rdy);
    logic [NUM_CH-1:0] d;
    d = NUM_CH'($urandom);
    d[lane] = b;
    cycle(1'b1, lane, d, 1'b0, rdy);
  endtask

  // Monitor: compares presented state and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(m_hold_v[k]));
        chk($sformatf("overflow%0d", k), 32'(overflow[k]), 32'(m_ovf[k]));
        if (m_hold_v[k])
          chk($sformatf("held_word%0d", k), 32'(out_word[k*WORD_W +: WORD_W]), 32'(m_hold_w[k]));
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_word%0d", k), 32'(out_word[k*WORD_W +: WORD_W]), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("sb_word%0d", k), 32'(out_word[k*WORD_W +: WORD_W]), 32'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; flush = 1'b0; out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Lane 0 word 1,0,1,1 with ready high.
    beat(0, 1'b1, 2'b11); beat(0, 1'b0, 2'b11); beat(0, 1'b1, 2'b11);
    chk("lat_before", 32'(out_valid[0]), 32'd0);
    beat(0, 1'b1, 2'b11);
    chk("lat_valid", 32'(out_valid[0]), 32'd1);
    chk("word_a", 32'(out_word[3:0]), 32'(EXP_A));
    chk("lane1_idle", 32'(out_valid[1]), 32'd0);

    // Asynchronous reset mid-cycle with a held word and a partial word.
    cycle(1'b0, 0, 2'b00, 1'b0, 2'b00);
    beat(0, 1'b1, 2'b00); beat(0, 1'b0, 2'b00);
    #3 reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_word", 32'(out_word), 32'd0);
    chk("async_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk); #1;
    beat(0, 1'b1, 2'b11); beat(0, 1'b1, 2'b11); beat(0, 1'b1, 2'b11);
    reset = 1'b0;
    beat(0, 1'b0, 2'b11); beat(0, 1'b1, 2'b11); beat(0, 1'b1, 2'b11); beat(0, 1'b0, 2'b11);
    chk("post_reset_word", 32'(out_word[3:0]), 32'(EXP_R));

    // Interleaved lanes.
    beat(0, 1'b1, 2'b11); beat(1, 1'b0, 2'b11);
    beat(0, 1'b1, 2'b11); beat(1, 1'b0, 2'b11);
    beat(0, 1'b1, 2'b11); beat(1, 1'b1, 2'b11);
    beat(0, 1'b0, 2'b11); beat(1, 1'b0, 2'b11);
    chk("il_valid1", 32'(out_valid[1]), 32'd1);
    chk("il_word1", 32'(out_word[7:4]), 32'(EXP_IL1));
    cycle(1'b0, 0, 2'b00, 1'b0, 2'b11);

    // Back-pressure on lane 1: one held, one parked, ninth bit dropped.
    beat(1, 1'b1, 2'b01); beat(1, 1'b1, 2'b01); beat(1, 1'b0, 2'b01); beat(1, 1'b0, 2'b01);
    beat(1, 1'b1, 2'b01); beat(1, 1'b0, 2'b01); beat(1, 1'b0, 2'b01); beat(1, 1'b1, 2'b01);
    beat(1, 1'b1, 2'b01);
    chk("bp_ovf1", 32'(overflow[1]), 32'd1);
    chk("bp_ovf0", 32'(overflow[0]), 32'd0);
    chk("bp_held", 32'(out_word[7:4]), 32'(EXP_W1));
    cycle(1'b0, 0, 2'b00, 1'b0, 2'b11);
    chk("bp_reload_valid", 32'(out_valid[1]), 32'd1);
    chk("bp_reload_word", 32'(out_word[7:4]), 32'(EXP_W2));

    // Flush clears overflow but keeps the held word.
    cycle(1'b0, 0, 2'b00, 1'b1, 2'b01);
    chk("flush_ovf", 32'(overflow[1]), 32'd0);
    chk("flush_keep", 32'(out_word[7:4]), 32'(EXP_W2));

    // Pop and beat in one cycle on a full lane.
    beat(1, 1'b0, 2'b01); beat(1, 1'b1, 2'b01); beat(1, 1'b1, 2'b01); beat(1, 1'b1, 2'b01);
    beat(1, 1'b1, 2'b11);
    chk("pb_word", 32'(out_word[7:4]), 32'(EXP_W3));
    chk("pb_ovf", 32'(overflow[1]), 32'd0);
    beat(1, 1'b0, 2'b11); beat(1, 1'b1, 2'b11); beat(1, 1'b0, 2'b11);
    chk("pb_next_valid", 32'(out_valid[1]), 32'd1);
    chk("pb_next_word", 32'(out_word[7:4]), 32'(EXP_W4));

    // Flush after two bits, with a beat in the flush cycle discarded.
    beat(0, 1'b1, 2'b11); beat(0, 1'b1, 2'b11);
    cycle(1'b1, 0, 2'b00, 1'b1, 2'b11);
    beat(0, 1'b1, 2'b11); beat(0, 1'b0, 2'b11); beat(0, 1'b1, 2'b11); beat(0, 1'b1, 2'b11);
    chk("flush_word", 32'(out_word[3:0]), 32'(EXP_A));

    // Random traffic alternating relaxed and heavy back-pressure phases.
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0] rdy;
      int lim;
      lim = ((i / 250) % 2 == 0) ? 3 : 7;
      for (int k = 0; k < int'(NUM_CH); k++)
        rdy[k] = (lim == 3) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NUM_CH - 1)),
            NUM_CH'($urandom), $urandom_range(0, 63) == 0, rdy);
    end

    repeat (10) cycle(1'b0, 0, 2'b00, 1'b0, 2'b11);
    for (int k = 0; k < int'(NUM_CH); k++)
      chk($sformatf("drain%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
